vector_issue_queue: RTL and testbench

//  Buffers APU requests from the host core and issues them one at a time to vector_decoder.

---
 rtl/vector_issue_queue_pkg.sv | 21 ++
 rtl/vector_issue_queue_if.sv | 23 ++
 rtl/vector_issue_queue_fifo.sv | 62 ++++++
 rtl/vector_issue_queue.sv | 108 ++++++++++
 tb/tb_vector_issue_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_issue_queue_pkg.sv
// Shared types for the vector issue queue: FSM states and the buffered APU request entry.
package vector_issue_queue_pkg;

    typedef logic [2:0][31:0] operands_t;
    typedef logic [5:0]       op_t;
    typedef logic [14:0]      flags_t;

    typedef enum logic [1:0] {
        ISSUE_IDLE,
        ISSUE_REQ,
        ISSUE_WAIT_RESP
    } issue_state_t;

    // 3x32 operands + 6 op bits + 15 flag bits = 117 bits
    typedef struct packed {
        operands_t operands;
        op_t       op;
        flags_t    flags;
    } apu_req_entry_t;

endpackage

// File: rtl/vector_issue_queue_if.sv
// APU-style request/response channel; the issuer is master, the responder is slave.
interface vector_issue_queue_if;
    import vector_issue_queue_pkg::*;

    logic        req;
    logic        gnt;
    operands_t   operands;
    op_t         op;
    flags_t      flags;
    logic        rvalid;
    logic [31:0] result;

    modport master (
        output req, output operands, output op, output flags,
        input  gnt, input  rvalid,   input  result
    );

    modport slave (
        input  req, input  operands, input  op, input  flags,
        output gnt, output rvalid,   output result
    );

endinterface

// File: rtl/vector_issue_queue_fifo.sv
// Request FIFO for the issue queue: power-of-two depth, separate occupancy counter.
module vec_req_fifo
    import vector_issue_queue_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = apu_req_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  entry_t                       data_i,
    output entry_t                       head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vector_issue_queue.sv
// Buffers core APU requests and issues them in order, one at a time, to the vector decoder,
// with a watchdog on the decoder response.
module vector_issue_queue
    import vector_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    vector_issue_queue_if.slave          apu,
    vector_issue_queue_if.master         dec,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic                         busy_o,
    output logic                         timeout_err_o
);

    localparam int WW = $clog2(TIMEOUT);

    issue_state_t   state_q, state_d;
    logic [WW-1:0]  wdog_q, wdog_d;
    logic           rvalid_q, rvalid_d;
    logic [31:0]    result_q, result_d;
    logic           err_q, err_d;
    logic           push, pop, full, empty;
    apu_req_entry_t wr_entry, head;

    assign wr_entry = '{operands: apu.operands, op: apu.op, flags: apu.flags};

    // Grant is held low while reset is asserted so every output reads 0 in reset
    assign apu.gnt = ~full & ~reset;
    assign push    = apu.req & apu.gnt;
    assign pop     = (state_q == ISSUE_REQ) & dec.gnt;

    vec_req_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (apu_req_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (wr_entry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occupancy_o)
    );

    assign dec.req      = (state_q == ISSUE_REQ);
    assign dec.operands = dec.req ? head.operands : '0;
    assign dec.op       = dec.req ? head.op       : '0;
    assign dec.flags    = dec.req ? head.flags    : '0;

    assign apu.rvalid    = rvalid_q;
    assign apu.result    = result_q;
    assign timeout_err_o = err_q;
    assign busy_o        = (occupancy_o != '0) | (state_q != ISSUE_IDLE);

    // A same-cycle push counts as non-empty so the next issue is not delayed a cycle
    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        rvalid_d = 1'b0;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ISSUE_IDLE: begin
                if (!empty || push) state_d = ISSUE_REQ;
            end
            ISSUE_REQ: begin
                if (dec.gnt) begin
                    state_d = ISSUE_WAIT_RESP;
                    wdog_d  = '0;
                end
            end
            ISSUE_WAIT_RESP: begin
                wdog_d = wdog_q + WW'(1);
                if (dec.rvalid) begin
                    rvalid_d = 1'b1;
                    result_d = dec.result;
                    state_d  = (!empty || push) ? ISSUE_REQ : ISSUE_IDLE;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ISSUE_IDLE;
                end
            end
            default: state_d = ISSUE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ISSUE_IDLE;
            wdog_q   <= '0;
            rvalid_q <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            rvalid_q <= rvalid_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_vector_issue_queue.sv
// Scoreboard bench for vector_issue_queue with a simple decoder model driven cycle by cycle.
module tb_vector_issue_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] occOut;
    logic       busyOut;
    logic       errOut;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] resultQ[$];
    logic [31:0] issueQ[$];
    int          decLatency = 0;
    bit          decPending = 0;
    int          decCount   = 0;
    logic [31:0] decHeld    = '0;
    logic        rvFire;

    vector_issue_queue_if apuBus ();
    vector_issue_queue_if decBus ();

    vector_issue_queue #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .apu           (apuBus),
        .dec           (decBus),
        .occupancy_o   (occOut),
        .busy_o        (busyOut),
        .timeout_err_o (errOut)
    );

    always #5 clk = ~clk;

    task automatic driveOp(input logic [31:0] tag);
        apuBus.req         = 1'b1;
        apuBus.operands[0] = 32'hC0DE_0000 ^ tag;
        apuBus.operands[1] = tag;
        apuBus.operands[2] = ~tag;
        apuBus.op          = tag[5:0];
        apuBus.flags       = tag[14:0];
    endtask

    // Advance one clock; the decoder model and the result monitor run around the edge
    task automatic tick();
        logic [31:0] exp;
        rvFire = decBus.rvalid;
        if (decBus.req === 1'b1 && decBus.gnt === 1'b1) begin
            total++;
            if (issueQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL issue_unexpected: got %h, required no issue", decBus.operands[1]);
            end else begin
                exp = issueQ.pop_front();
                if (decBus.operands[1] !== exp || decBus.op !== exp[5:0] ||
                    decBus.operands[0] !== (32'hC0DE_0000 ^ exp) || decBus.flags !== exp[14:0]) begin
                    bad++;
                    $display("[TB] FAIL issue_order: got %h op %h, required %h op %h",
                             decBus.operands[1], decBus.op, exp, exp[5:0]);
                end
            end
            decHeld    = decBus.operands[1];
            decPending = (decLatency > 0);
            decCount   = decLatency;
        end
        @(posedge clk);
        #1;
        decBus.rvalid = 1'b0;
        if (decPending) begin
            decCount--;
            if (decCount == 0) begin
                decBus.rvalid = 1'b1;
                decBus.result = decHeld;
                decPending    = 0;
            end
        end
        total++;
        if (apuBus.rvalid !== rvFire) begin
            bad++;
            $display("[TB] FAIL rvalid_timing: got %b, required %b", apuBus.rvalid, rvFire);
        end
        if (apuBus.rvalid === 1'b1) begin
            total++;
            if (resultQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL result_unexpected: got %h, required no result", apuBus.result);
            end else begin
                exp = resultQ.pop_front();
                if (apuBus.result !== exp) begin
                    bad++;
                    $display("[TB] FAIL result_value: got %h, required %h", apuBus.result, exp);
                end
            end
        end
    endtask

    task automatic waitDrain(input int bound, input string name);
        int n = 0;
        while ((resultQ.size() != 0 || busyOut !== 1'b0) && n < bound) begin
            tick();
            n++;
        end
        total++;
        if (resultQ.size() != 0 || busyOut !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_drain: pending=%0d busy=%b, required 0 and 0",
                     name, resultQ.size(), busyOut);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        apuBus.req = 1'b0;
        driveOp(32'h0000_0A11);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({apuBus.gnt, apuBus.rvalid, decBus.req, busyOut, errOut} !== 5'b0 ||
            occOut !== 3'd0 || apuBus.result !== 32'h0 || decBus.operands !== '0 ||
            decBus.op !== 6'h0 || decBus.flags !== 15'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: gnt=%b rv=%b req=%b busy=%b err=%b occ=%0d, required all 0",
                     apuBus.gnt, apuBus.rvalid, decBus.req, busyOut, errOut, occOut);
        end
        apuBus.req = 1'b0;
        reset      = 1'b0;
        #1;
        total++;
        if (apuBus.gnt !== 1'b1 || occOut !== 3'd0 || busyOut !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: gnt=%b occ=%0d busy=%b, required 1 0 0",
                     apuBus.gnt, occOut, busyOut);
        end
    endtask

    task automatic test_single();
        decBus.gnt = 1'b1;
        decLatency = 3;
        driveOp(32'h0000_1234);
        total++;
        if (decBus.req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_no_bypass: req=%b, required 0", decBus.req);
        end
        resultQ.push_back(32'h0000_1234);
        issueQ.push_back(32'h0000_1234);
        tick();
        apuBus.req = 1'b0;
        total++;
        if (decBus.req !== 1'b1 || occOut !== 3'd1) begin
            bad++;
            $display("[TB] FAIL single_issue: req=%b occ=%0d, required 1 1", decBus.req, occOut);
        end
        waitDrain(20, "single");
        tick();
        total++;
        if (apuBus.result !== 32'h0000_1234 || apuBus.rvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_hold: result=%h rv=%b, required 00001234 0",
                     apuBus.result, apuBus.rvalid);
        end
    endtask

    task automatic test_burst_full();
        int n = 0;
        decBus.gnt = 1'b0;
        decLatency = 2;
        for (int i = 0; i < 4; i++) begin
            driveOp(32'hB000_0010 + 32'(i));
            total++;
            if (apuBus.gnt !== 1'b1) begin
                bad++;
                $display("[TB] FAIL burst_gnt%0d: got %b, required 1", i, apuBus.gnt);
            end
            resultQ.push_back(32'hB000_0010 + 32'(i));
            issueQ.push_back(32'hB000_0010 + 32'(i));
            tick();
        end
        driveOp(32'hB000_0014);
        total++;
        if (apuBus.gnt !== 1'b0 || occOut !== 3'd4 || decBus.req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL burst_full: gnt=%b occ=%0d req=%b, required 0 4 1",
                     apuBus.gnt, occOut, decBus.req);
        end
        decBus.gnt = 1'b1;
        #1;
        total++;
        if (apuBus.gnt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL burst_pop_no_gnt: got %b, required 0", apuBus.gnt);
        end
        tick();
        while (apuBus.gnt !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (n != 0 || apuBus.gnt !== 1'b1) begin
            bad++;
            $display("[TB] FAIL burst_fifth_accept: waited %0d extra cycles gnt=%b, required 0 and 1",
                     n, apuBus.gnt);
        end
        resultQ.push_back(32'hB000_0014);
        issueQ.push_back(32'hB000_0014);
        tick();
        apuBus.req = 1'b0;
        waitDrain(100, "burst");
    endtask

    task automatic test_push_on_rvalid();
        int n = 0;
        decBus.gnt = 1'b1;
        decLatency = 3;
        driveOp(32'h0000_4A4A);
        resultQ.push_back(32'h0000_4A4A);
        issueQ.push_back(32'h0000_4A4A);
        tick();
        apuBus.req = 1'b0;
        while (decBus.rvalid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (decBus.rvalid !== 1'b1 || occOut !== 3'd0 || decBus.req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rvpush_setup: rv=%b occ=%0d req=%b, required 1 0 0",
                     decBus.rvalid, occOut, decBus.req);
        end
        driveOp(32'h0000_5B5B);
        resultQ.push_back(32'h0000_5B5B);
        issueQ.push_back(32'h0000_5B5B);
        tick();
        apuBus.req = 1'b0;
        total++;
        if (decBus.req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rvpush_direct_req: got %b, required 1", decBus.req);
        end
        waitDrain(20, "rvpush");
    endtask

    task automatic test_watchdog();
        decBus.gnt = 1'b1;
        decLatency = 0;
        driveOp(32'h0000_DEAD);
        issueQ.push_back(32'h0000_DEAD);
        tick();
        apuBus.req = 1'b0;
        total++;
        if (decBus.req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wdog_issue: req=%b, required 1", decBus.req);
        end
        tick();
        for (int i = 0; i < 63; i++) tick();
        total++;
        if (errOut !== 1'b0 || busyOut !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wdog_early: err=%b busy=%b, required 0 1", errOut, busyOut);
        end
        tick();
        total++;
        if (errOut !== 1'b1 || busyOut !== 1'b0 || decBus.req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wdog_fire: err=%b busy=%b req=%b, required 1 0 0",
                     errOut, busyOut, decBus.req);
        end
        repeat (3) tick();
        total++;
        if (errOut !== 1'b1 || apuBus.gnt !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wdog_sticky: err=%b gnt=%b, required 1 1", errOut, apuBus.gnt);
        end
    endtask

    task automatic test_reset_in_flight();
        decBus.gnt = 1'b1;
        decLatency = 0;
        for (int i = 0; i < 3; i++) begin
            driveOp(32'hF100_0000 + 32'(i));
            issueQ.push_back(32'hF100_0000 + 32'(i));
            tick();
        end
        apuBus.req = 1'b0;
        total++;
        if (occOut !== 3'd2 || busyOut !== 1'b1 || errOut !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_setup: occ=%0d busy=%b err=%b, required 2 1 1",
                     occOut, busyOut, errOut);
        end
        reset = 1'b1;
        #1;
        total++;
        if (occOut !== 3'd0 || busyOut !== 1'b0 || errOut !== 1'b0 || apuBus.gnt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_async: occ=%0d busy=%b err=%b gnt=%b, required 0 0 0 0",
                     occOut, busyOut, errOut, apuBus.gnt);
        end
        issueQ.delete();
        decPending = 0;
        tick();
        reset      = 1'b0;
        decLatency = 2;
        #1;
        total++;
        if (apuBus.gnt !== 1'b1 || occOut !== 3'd0) begin
            bad++;
            $display("[TB] FAIL midreset_release: gnt=%b occ=%0d, required 1 0", apuBus.gnt, occOut);
        end
        repeat (8) tick();
        driveOp(32'h0000_7777);
        resultQ.push_back(32'h0000_7777);
        issueQ.push_back(32'h0000_7777);
        tick();
        apuBus.req = 1'b0;
        total++;
        if (decBus.req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_new_issue: req=%b, required 1", decBus.req);
        end
        waitDrain(20, "midreset");
    endtask

    initial begin
        reset         = 1'b1;
        apuBus.req    = 1'b0;
        decBus.gnt    = 1'b0;
        decBus.rvalid = 1'b0;
        decBus.result = '0;
        test_reset();
        test_single();
        test_burst_full();
        test_push_on_rvalid();
        test_watchdog();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
